// File: rtl/grf_scoreboard.sv
`default_nettype none
// ============================================================================
// grf_scoreboard : 2R/1W register file with write bypass and per-register
//                  pending-write counters. Optional macro: GRF_TRACE_EN.
// Revision       : 1.0
// ============================================================================
module grf_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              busy1,
  output logic              busy2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [31:0]       pc,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_wa,
  output logic              iss_rdy
);

  localparam int               DEPTH   = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [CNT_W-1:0]  pend_q [DEPTH];
  logic [CNT_W-1:0]  pend_d [DEPTH];
  logic              wr_en;

  assign wr_en = we && (wa != '0);

  // Same-cycle write-back is forwarded so readers see it with zero latency.
  assign rd1 = (wr_en && (wa == ra1)) ? wd : regs_q[ra1];
  assign rd2 = (wr_en && (wa == ra2)) ? wd : regs_q[ra2];

  assign busy1 = (ra1 != '0) && (pend_q[ra1] != '0) &&
                 !(we && (wa == ra1) && (pend_q[ra1] == CNT_ONE));
  assign busy2 = (ra2 != '0) && (pend_q[ra2] != '0) &&
                 !(we && (wa == ra2) && (pend_q[ra2] == CNT_ONE));

  assign iss_rdy = (iss_wa == '0) || (pend_q[iss_wa] != CNT_MAX) ||
                   (we && (wa == iss_wa));

  always_comb begin
    logic inc;
    logic dec;
    inc = 1'b0;
    dec = 1'b0;
    regs_d = regs_q;
    pend_d = pend_q;
    if (wr_en) regs_d[wa] = wd;
    // Index 0 is skipped so its counter stays at its reset value of 0.
    for (int r = 1; r < DEPTH; r++) begin
      inc = iss_en && iss_rdy && (iss_wa == ADDR_W'(r));
      dec = we && (wa == ADDR_W'(r)) && (pend_q[r] != '0);
      if (inc && !dec)      pend_d[r] = pend_q[r] + CNT_ONE;
      else if (dec && !inc) pend_d[r] = pend_q[r] - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_q[r] <= '0;
        pend_q[r] <= '0;
      end
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

`ifdef GRF_TRACE_EN
  always_ff @(posedge clk) begin
    if (reset && wr_en) $display("@%h: $%d <= %h", pc, wa, wd);
  end
`else
  logic unused_pc;
  assign unused_pc = ^pc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_grf_scoreboard.sv
`default_nettype none
// ============================================================================
// tb_grf_scoreboard : directed stimulus with a queue-based scoreboard monitor.
// Revision          : 1.0
// ============================================================================
module tb_grf_scoreboard;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  ra1 = '0, ra2 = '0, wa = '0, iss_wa = '0;
  logic [31:0] rd1, rd2, wd = '0, pc = 32'h3004;
  logic        busy1, busy2, we = 1'b0, iss_en = 1'b0, iss_rdy;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       nm;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        b1;
    logic        b2;
    logic        rdy;
  } exp_t;

  exp_t exp_q[$];

  grf_scoreboard #(.DATA_W(32), .ADDR_W(5), .CNT_W(2)) dut (
    .clk(clk), .reset(reset),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .busy1(busy1), .busy2(busy2),
    .we(we), .wa(wa), .wd(wd), .pc(pc),
    .iss_en(iss_en), .iss_wa(iss_wa), .iss_rdy(iss_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, string f, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s: got %h expected %h", nm, f, act, req);
    end
  endtask

  // Monitor: compares the DUT against the oldest queued expectation each negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.nm, "rd1", rd1, e.rd1);
        chk(e.nm, "rd2", rd2, e.rd2);
        chk(e.nm, "busy1", {31'b0, busy1}, {31'b0, e.b1});
        chk(e.nm, "busy2", {31'b0, busy2}, {31'b0, e.b2});
        chk(e.nm, "iss_rdy", {31'b0, iss_rdy}, {31'b0, e.rdy});
      end
    end
  end

  task automatic push(string nm, logic [31:0] e1, logic [31:0] e2,
                      logic eb1, logic eb2, logic erdy);
    exp_t e;
    e.nm = nm; e.rd1 = e1; e.rd2 = e2; e.b1 = eb1; e.b2 = eb2; e.rdy = erdy;
    exp_q.push_back(e);
  endtask

  task automatic step(string nm, logic w, logic [4:0] a, logic [31:0] d,
                      logic [4:0] r1, logic [4:0] r2, logic ie, logic [4:0] ia,
                      logic [31:0] e1, logic [31:0] e2,
                      logic eb1, logic eb2, logic erdy);
    @(posedge clk);
    #1;
    we = w; wa = a; wd = d; ra1 = r1; ra2 = r2; iss_en = ie; iss_wa = ia;
    push(nm, e1, e2, eb1, eb2, erdy);
  endtask

  initial begin
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 32; i++)
      step("rst_sweep", 0, 0, 0, 5'(i), 5'(31 - i), 1, 5'(i), 0, 0, 0, 0, 1);
    @(posedge clk);
    #1 reset = 1'b1;

    //   name        we wa  wd            ra1 ra2 ie ia  rd1           rd2      b1 b2 rdy
    step("wr_bypass", 1, 5, 32'hDEADBEEF, 5, 0, 0, 0, 32'hDEADBEEF, 0,       0, 0, 1);
    step("rd_stored", 0, 0, 0,            5, 0, 0, 0, 32'hDEADBEEF, 0,       0, 0, 1);
    step("wr_r0",     1, 0, 1,            0, 0, 0, 0, 0,            0,       0, 0, 1);
    step("rd_r0",     0, 0, 0,            0, 0, 0, 0, 0,            0,       0, 0, 1);
    step("iss8_a",    0, 0, 0,            8, 0, 1, 8, 0,            0,       0, 0, 1);
    step("iss8_b",    0, 0, 0,            8, 0, 1, 8, 0,            0,       1, 0, 1);
    step("iss8_c",    0, 0, 0,            8, 0, 1, 8, 0,            0,       1, 0, 1);
    step("sat8",      0, 0, 0,            8, 0, 0, 8, 0,            0,       1, 0, 0);
    step("sat8_wr",   1, 8, 32'h88,       8, 0, 1, 8, 32'h88,       0,       1, 0, 1);
    step("sat8_hold", 0, 0, 0,            8, 0, 0, 8, 32'h88,       0,       1, 0, 0);
    step("drain8_3",  1, 8, 32'h81,       8, 0, 0, 8, 32'h81,       0,       1, 0, 1);
    step("drain8_2",  1, 8, 32'h82,       8, 0, 0, 8, 32'h82,       0,       1, 0, 1);
    step("drain8_1",  1, 8, 32'h83,       8, 0, 0, 8, 32'h83,       0,       0, 0, 1);
    step("idle8",     0, 0, 0,            8, 0, 0, 8, 32'h83,       0,       0, 0, 1);
    step("iss9",      0, 0, 0,            0, 9, 1, 9, 0,            0,       0, 0, 1);
    step("last_wr9",  1, 9, 7,            0, 9, 0, 0, 0,            7,       0, 0, 1);
    step("after9",    0, 0, 0,            0, 9, 0, 0, 0,            7,       0, 0, 1);
    step("iss9_p1",   0, 0, 0,            0, 9, 1, 9, 0,            7,       0, 0, 1);
    step("iss9_p2",   0, 0, 0,            0, 9, 1, 9, 0,            7,       0, 1, 1);
    step("wr9_p2",    1, 9, 32'h17,       0, 9, 0, 0, 0,            32'h17,  0, 1, 1);
    step("hold9_p1",  0, 0, 0,            0, 9, 0, 0, 0,            32'h17,  0, 1, 1);
    step("wr9_p1",    1, 9, 32'h27,       0, 9, 0, 0, 0,            32'h27,  0, 0, 1);
    step("idle9",     0, 0, 0,            0, 9, 0, 0, 0,            32'h27,  0, 0, 1);
    step("untrk3",    1, 3, 32'h33,       3, 0, 0, 3, 32'h33,       0,       0, 0, 1);
    step("untrk3_rd", 0, 0, 0,            3, 3, 0, 3, 32'h33,       32'h33,  0, 0, 1);
    step("iss4",      0, 0, 0,            4, 0, 1, 4, 0,            0,       0, 0, 1);
    step("iss_wr4",   1, 4, 32'h44,       4, 4, 1, 4, 32'h44,       32'h44,  0, 0, 1);
    step("hold4",     0, 0, 0,            4, 4, 0, 4, 32'h44,       32'h44,  1, 1, 1);
    step("iss0",      0, 0, 0,            0, 0, 1, 0, 0,            0,       0, 0, 1);
    step("iss0_rd",   0, 0, 0,            0, 0, 1, 0, 0,            0,       0, 0, 1);
    step("pre_rst",   0, 0, 0,            4, 5, 0, 8, 32'h44,       32'hDEADBEEF, 1, 0, 1);

    // Asynchronous reset pulse entirely between clock edges.
    @(posedge clk);
    #1;
    ra1 = 4; ra2 = 5; iss_wa = 4; we = 0; iss_en = 0;
    reset = 1'b0;
    #2 reset = 1'b1;
    push("async_rst", 0, 0, 0, 0, 1);

    step("post_rst",  0, 0, 0,            8, 3, 0, 8, 0,            0,       0, 0, 1);
    step("post_rst4", 0, 0, 0,            4, 9, 0, 0, 0,            0,       0, 0, 1);

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
